// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// Receive-side endpoint of a write-only SPI link (mode 0, MSB first).
// The three SPI lines are oversampled in the clk_i domain. Each completed
// word is presented on a valid/ready port.
//
// Ports:
//   clk_i          system clock, at least 4x the spi_sclk frequency
//   rst_ni         asynchronous active-low reset
//   spi_sclk       SPI clock (idle low, data sampled on the rising edge)
//   spi_sdo        serial data from the master, MSB first
//   spi_cs         chip select, active low
//   frame_data_o   received word
//   frame_valid_o  word available
//   frame_ready_i  consumer accepts the word
//   frame_err_o    one-cycle pulse when spi_cs rises mid-frame
//   overrun_o      sticky; a word was dropped because the output was full
//   clr_i          synchronous clear of overrun_o
//   frame_cnt_o    count of words loaded into the output register (wraps)
//   busy_o         high while the deframer is in SHIFT
module spi_slave_rx #(
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               spi_sclk,
  input  logic               spi_sdo,
  input  logic               spi_cs,
  output logic [FRAME_W-1:0] frame_data_o,
  output logic               frame_valid_o,
  input  logic               frame_ready_i,
  output logic               frame_err_o,
  output logic               overrun_o,
  input  logic               clr_i,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic               busy_o
);

  localparam int BC_W = $clog2(FRAME_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic sclk_m, sclk_s, sclk_prev;
  logic sdo_m, sdo_s;
  logic cs_m, cs_s;
  logic rise;

  state_t             state, state_n;
  logic [BC_W-1:0]    bit_cnt, bit_cnt_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [FRAME_W-1:0] word_q, word_n;
  logic               offer_q, offer_n;
  logic               err_n;

  // Two-flop synchronizers. sclk has a third flop for edge detection.
  // cs resets to its inactive (high) level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_m    <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_prev <= 1'b0;
      sdo_m     <= 1'b0;
      sdo_s     <= 1'b0;
      cs_m      <= 1'b1;
      cs_s      <= 1'b1;
    end else begin
      sclk_m    <= spi_sclk;
      sclk_s    <= sclk_m;
      sclk_prev <= sclk_s;
      sdo_m     <= spi_sdo;
      sdo_s     <= sdo_m;
      cs_m      <= spi_cs;
      cs_s      <= cs_m;
    end
  end

  assign rise = sclk_s & ~sclk_prev;

  // Deframer state. A completed word is held in word_q for one cycle
  // (offer_q) before it reaches the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      word_q      <= '0;
      offer_q     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      word_q      <= word_n;
      offer_q     <= offer_n;
      frame_err_o <= err_n;
    end
  end

  // CS deassertion takes priority over a coincident sclk rise. That bit
  // is dropped, and the exit is judged on the count before that bit.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    word_n    = word_q;
    offer_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_n = '0;
        shreg_n   = '0;
        if (!cs_s) state_n = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          state_n   = IDLE;
          err_n     = (bit_cnt != '0);
          bit_cnt_n = '0;
          shreg_n   = '0;
        end else if (rise) begin
          shreg_n = {shreg[FRAME_W-2:0], sdo_s};
          if (bit_cnt == BC_W'(FRAME_W - 1)) begin
            bit_cnt_n = '0;
            offer_n   = 1'b1;
            word_n    = {shreg[FRAME_W-2:0], sdo_s};
          end else begin
            bit_cnt_n = bit_cnt + BC_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state == SHIFT);

  // Output register. A word is dropped if the register still holds an
  // unaccepted word. A dropped word leaves the data and the count untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_data_o  <= '0;
      frame_valid_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else if (offer_q && (!frame_valid_o || frame_ready_i)) begin
      frame_data_o  <= word_q;
      frame_valid_o <= 1'b1;
      frame_cnt_o   <= frame_cnt_o + CNT_W'(1);
    end else if (frame_valid_o && frame_ready_i) begin
      frame_valid_o <= 1'b0;
    end
  end

  // A new overrun wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_o <= 1'b0;
    end else if (offer_q && frame_valid_o && !frame_ready_i) begin
      overrun_o <= 1'b1;
    end else if (clr_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
// Self-checking bench for spi_slave_rx (FRAME_W=16, CNT_W=2 so the frame
// counter wraps). A table of frames is driven over SPI at clk_i/8.
// Words expected at the output are queued as they are sent, and a
// monitor compares them against each valid/ready handshake.
// Hand-written sequences cover overrun, reset mid-frame and ignored clocks.
module tb_spi_slave_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        spi_sclk;
  logic        spi_sdo;
  logic        spi_cs;
  logic [15:0] frame_data_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic        frame_err_o;
  logic        overrun_o;
  logic        clr_i;
  logic [1:0]  frame_cnt_o;
  logic        busy_o;

  typedef struct {
    logic [15:0] data;
    int          nbits;
    bit          keep_cs;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  cnt;
  } exp_t;

  vec_t       vecs[10];
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] model_cnt;
  int         tests = 0;
  int         fails = 0;
  int         err_pulses = 0;
  int         err_before;

  spi_slave_rx #(.FRAME_W(16), .CNT_W(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .spi_sclk      (spi_sclk),
    .spi_sdo       (spi_sdo),
    .spi_cs        (spi_cs),
    .frame_data_o  (frame_data_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .frame_err_o   (frame_err_o),
    .overrun_o     (overrun_o),
    .clr_i         (clr_i),
    .frame_cnt_o   (frame_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic sendBits(input logic [15:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_sdo = data[i];
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (spi_cs) begin
      spi_cs = 1'b0;
      tick(4);
    end
    err_before = err_pulses;
    if (v.nbits == 16) begin
      model_cnt = model_cnt + 2'd1;
      exp_q.push_back('{v.data, model_cnt});
    end
    sendBits(v.data, v.nbits);
    tick(6);
    if (v.keep_cs) begin
      checkOutput("busy_between_frames", busy_o, 1);
    end else begin
      spi_cs = 1'b1;
      tick(6);
      checkOutput("busy_after_cs", busy_o, 0);
    end
    checkOutput("err_pulses", err_pulses - err_before, v.exp_err);
    checkOutput("word_delivered", exp_q.size(), 0);
    checkOutput("valid_cleared", frame_valid_o, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, frame_data_o, 0);
    checkOutput({tag, "_valid"}, frame_valid_o, 0);
    checkOutput({tag, "_err"}, frame_err_o, 0);
    checkOutput({tag, "_overrun"}, overrun_o, 0);
    checkOutput({tag, "_cnt"}, frame_cnt_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
  endtask

  // Scoreboard side: every accepted word must match the oldest expected one.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (frame_err_o) err_pulses++;
      if (frame_valid_o && frame_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_word: got %0h, required none", frame_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word_data", frame_data_o, mon_e.data);
          checkOutput("word_cnt", frame_cnt_o, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{16'hA5C3, 16, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16, 1'b0, 1'b0};
    vecs[3] = '{16'h01A5, 9,  1'b0, 1'b1};
    vecs[4] = '{16'h0F0F, 16, 1'b0, 1'b0};
    vecs[5] = '{16'h0001, 16, 1'b0, 1'b0};
    vecs[6] = '{16'h8002, 16, 1'b0, 1'b0};
    vecs[7] = '{16'h0003, 16, 1'b0, 1'b0};
    vecs[8] = '{16'h7FF4, 16, 1'b0, 1'b0};
    vecs[9] = '{16'h0005, 16, 1'b0, 1'b0};

    rst_ni        = 1'b0;
    spi_sclk      = 1'b0;
    spi_sdo       = 1'b0;
    spi_cs        = 1'b1;
    frame_ready_i = 1'b1;
    clr_i         = 1'b0;
    model_cnt     = 2'd0;
    #1;
    checkAllZero("reset");
    tick(3);
    rst_ni = 1'b1;
    tick(2);

    // sclk activity while CS is high must not start a frame.
    spi_sdo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
    tick(6);
    checkOutput("cs_high_busy", busy_o, 0);
    checkOutput("cs_high_valid", frame_valid_o, 0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Overrun: the second word is dropped while the first is unaccepted.
    frame_ready_i = 1'b0;
    spi_cs = 1'b0;
    tick(4);
    err_before = err_pulses;
    model_cnt = model_cnt + 2'd1;
    exp_q.push_back('{16'h1111, model_cnt});
    sendBits(16'h1111, 16);
    sendBits(16'h2222, 16);
    tick(6);
    spi_cs = 1'b1;
    tick(6);
    checkOutput("ovr_data_held", frame_data_o, 16'h1111);
    checkOutput("ovr_valid", frame_valid_o, 1);
    checkOutput("ovr_flag", overrun_o, 1);
    checkOutput("ovr_cnt", frame_cnt_o, model_cnt);
    checkOutput("ovr_no_err", err_pulses - err_before, 0);
    frame_ready_i = 1'b1;
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(2);
    checkOutput("ovr_cleared", overrun_o, 0);
    checkOutput("ovr_valid_cleared", frame_valid_o, 0);
    checkOutput("ovr_word_delivered", exp_q.size(), 0);

    // Reset mid-frame: everything clears at once, and no error pulse follows.
    spi_cs = 1'b0;
    tick(4);
    err_before = err_pulses;
    sendBits(16'h0016, 5);
    tick(2);
    rst_ni = 1'b0;
    spi_cs = 1'b1;
    #1;
    checkAllZero("mid_reset");
    tick(2);
    rst_ni = 1'b1;
    model_cnt = 2'd0;
    tick(4);
    checkOutput("post_reset_no_err", err_pulses - err_before, 0);
    applyStimulus('{16'hBEEF, 16, 1'b0, 1'b0});

    tick(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side endpoint of the write-only SPI link driven by spi_master: spi_sclk, spi_sdo, spi_cs.
- Oversamples the three SPI lines in the clk_i domain and deframes MSB-first words.
- Presents each completed word on a valid/ready port for register-file or loopback checking.
- Sits on-chip, or in the test FPGA as the far end of the link.

Parameters:
- FRAME_W, 16, bits per frame (2..64).
- CNT_W, 8, width of the accepted-frame counter (wraps).

Ports:
- clk_i  in  1  system clock; must be >= 4x the spi_sclk frequency.
- rst_ni  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, mode 0: idle low, data sampled on the rising edge.
- spi_sdo  in  1  serial data from the master, MSB first.
- spi_cs  in  1  chip select, active low.
- frame_data_o  out  FRAME_W  received word.
- frame_valid_o  out  1  word available.
- frame_ready_i  in  1  consumer accepts the word.
- frame_err_o  out  1  one-cycle pulse: spi_cs deasserted mid-frame.
- overrun_o  out  1  sticky: word dropped because the output was still full.
- clr_i  in  1  synchronous clear of overrun_o.
- frame_cnt_o  out  CNT_W  count of words accepted into the output register.
- busy_o  out  1  high while state is SHIFT.

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0.
  - State IDLE, bit counter 0, shift register 0.
  - Synchronizer flops reset: sclk/sdo sync to 0, cs sync to 1.
- Synchronization and edge detection:
  - Each SPI input passes through 2 flops.
  - A third flop on the synced sclk gives sclk_prev.
  - rise = sclk_s & ~sclk_prev. sdo_s is sampled in the same cycle as rise.
- FSM states:
  - IDLE: cs_s=1. Shift register and counter held at 0. On cs_s=0 go to SHIFT.
  - SHIFT: on rise, shreg <= {shreg[FRAME_W-2:0], sdo_s} and cnt <= cnt+1.
  - Frame completion: when a rise brings cnt to FRAME_W, the completed word {shreg[FRAME_W-2:0], sdo_s} is offered to the output register and cnt <= 0. The FSM stays in SHIFT, so back-to-back frames within one CS assertion are supported.
  - SHIFT -> IDLE on cs_s=1:
    - cnt != 0: pulse frame_err_o for one cycle and discard the partial word.
    - cnt == 0: clean exit, no pulse.
- Output register:
  - Loads when a word is offered and (frame_valid_o=0 or frame_ready_i=1 in the same cycle). Then frame_valid_o=1 and frame_cnt_o increments, wrapping at 2^CNT_W.
  - Offered while frame_valid_o=1 and frame_ready_i=0: word dropped, overrun_o set. frame_data_o and frame_cnt_o are unchanged.
  - frame_valid_o clears on valid&ready with no new load in the same cycle.
  - frame_data_o is stable while frame_valid_o=1 and not accepted.
- Latency: frame_valid_o rises on the 2nd clk_i edge after the edge where the final rise is detected, i.e. 4 clk_i edges after spi_sclk goes high at a synchronizer input.
- overrun_o:
  - Cleared only by clr_i or reset.
  - clr_i and a new overrun in the same cycle: set wins.
- Boundary cases:
  - Rises while cs_s=1 are ignored.
  - A cs_s rise coinciding with a rise: that bit is not shifted and the transition is handled as a cs rise with the current cnt.
  - Reset mid-frame discards all state immediately; no frame_err_o pulse.
  - spi_sdo is ignored outside rise cycles.

Test Plan:
- Single frame: CS low, shift 16'hA5C3 MSB-first at clk_i/8, ready=1 -> one valid pulse with data 16'hA5C3, frame_cnt_o=1, frame_err_o never pulses.
- Back-to-back: two frames 16'h1234, 16'hFFFF in one CS assertion, ready=1 -> two valid handshakes in order, frame_cnt_o=2, busy_o high throughout.
- Abort: CS low, 9 bits sent, CS high -> exactly one frame_err_o pulse, no valid, cnt restarts so the next full frame 16'h0F0F is received correctly.
- Overrun: ready=0, send 16'h1111 then 16'h2222 -> frame_data_o stays 16'h1111, overrun_o=1, frame_cnt_o=1. Then ready=1 and clr_i -> handshake completes, overrun_o=0.
- Reset mid-frame: rst_ni low after 5 bits, then release and send 16'hBEEF -> all outputs 0 during reset, next word 16'hBEEF, no error pulse.
- Counter wrap (CNT_W=2): 5 frames with ready=1 -> frame_cnt_o sequence 1,2,3,0,1.
